// File: rtl/imem_boot_if.sv
// imem_boot_if: program-stream handshake plus instruction-memory write port of the boot loader
interface imem_boot_if #(
  parameter int ADDR_W = 8
) ();
  logic prog_valid;
  logic prog_ready;
  logic [31:0] prog_data;
  logic prog_last;
  logic imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0] imem_wdata;
  modport master (
    output prog_valid, prog_data, prog_last,
    input  prog_ready, imem_we, imem_waddr, imem_wdata
  );
  modport slave (
    input  prog_valid, prog_data, prog_last,
    output prog_ready, imem_we, imem_waddr, imem_wdata
  );
endinterface

// File: rtl/imem_boot_ctrl.sv
// imem_boot_ctrl: streams a program into imem from address 0 and releases core reset after a settle delay.
// IMEM_BOOT_CHECKSUM_EN: the last beat carries a 32-bit wrapping sum of the image instead of an instruction.
module imem_boot_ctrl #(
  parameter int DEPTH = 256,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int RELEASE_DELAY = 2
) (
  input  logic clk,
  input  logic reset,
  imem_boot_if.slave bus,
  input  logic reload,
  output logic core_reset,
  output logic boot_done,
  output logic boot_err,
  output logic [ADDR_W:0] word_count
);
  localparam int HOLD_W = $clog2(RELEASE_DELAY + 1);
  typedef enum logic [1:0] {LOAD, HOLD, RUN, ERR} state_t;
  state_t state_q, state_d;
  logic [ADDR_W:0] count_q, count_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic core_reset_q, core_reset_d;
  logic boot_done_q, boot_done_d;
  logic boot_err_q, boot_err_d;
  logic fire, full, wr, to_hold, to_err;
  assign bus.prog_ready = (state_q == LOAD) && !reset;
  assign fire = bus.prog_valid && bus.prog_ready;
  assign full = count_q == (ADDR_W + 1)'(DEPTH);
`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;
  logic sum_ok;
  assign sum_ok = sum_q == bus.prog_data;
  assign wr = fire && !bus.prog_last && !full;
  assign to_hold = fire && bus.prog_last && sum_ok;
  assign to_err = fire && (bus.prog_last ? !sum_ok : full);
`else
  assign wr = fire && !full;
  assign to_hold = wr && bus.prog_last;
  assign to_err = fire && full;
`endif
  assign bus.imem_we = wr;
  assign bus.imem_waddr = count_q[ADDR_W-1:0];
  assign bus.imem_wdata = bus.prog_data;
  assign core_reset = core_reset_q;
  assign boot_done = boot_done_q;
  assign boot_err = boot_err_q;
  assign word_count = count_q;
  always_comb begin
    state_d = state_q;
    count_d = count_q + {{ADDR_W{1'b0}}, wr};
    hold_d = hold_q;
`ifdef IMEM_BOOT_CHECKSUM_EN
    sum_d = wr ? sum_q + bus.prog_data : sum_q;
`endif
    unique case (state_q)
      LOAD: begin
        state_d = to_err ? ERR : to_hold ? HOLD : LOAD;
        hold_d = to_hold ? HOLD_W'(RELEASE_DELAY) : hold_q;
      end
      HOLD: begin
        hold_d = hold_q - 1'b1;
        state_d = (hold_q == HOLD_W'(1)) ? RUN : HOLD;
      end
      default: if (reload) begin
        state_d = LOAD;
        count_d = '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
        sum_d = '0;
`endif
      end
    endcase
    core_reset_d = state_d != RUN;
    boot_done_d = state_d == RUN;
    boot_err_d = state_d == ERR;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOAD;
      count_q <= '0;
      hold_q <= '0;
      core_reset_q <= 1'b1;
      boot_done_q <= 1'b0;
      boot_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hold_q <= hold_d;
      core_reset_q <= core_reset_d;
      boot_done_q <= boot_done_d;
      boot_err_q <= boot_err_d;
    end
  end
`ifdef IMEM_BOOT_CHECKSUM_EN
  always_ff @(posedge clk) sum_q <= reset ? '0 : sum_d;
`endif
endmodule

// File: tb/tb_imem_boot_ctrl.sv
// tb_imem_boot_ctrl: two loaders (DEPTH 256 and 4) share one stimulus stream and are checked every cycle
// against a phase/timestamp model of the load, plus hand-computed literal expectations.
module tb_imem_boot_ctrl;
  localparam int RD = 2;
  localparam int M_LOAD = 0, M_HOLD = 1, M_RUN = 2, M_ERR = 3;
`ifdef IMEM_BOOT_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, reload = 1'b0, pv = 1'b0, pl = 1'b0;
  logic [31:0] pd = '0;
  logic cr0, bd0, be0, cr1, bd1, be1;
  logic [8:0] wc0;
  logic [2:0] wc1;
  int tests = 0, fails = 0, cyc = 0;
  bit armed = 1'b0;
  int mode [2] = '{M_LOAD, M_LOAD};
  int cnt [2] = '{0, 0};
  int rel [2] = '{0, 0};
  logic [31:0] sum [2] = '{32'd0, 32'd0};
  logic [31:0] mm [2][256];
  bit mv [2][256];
  logic [31:0] sh [2][256];
  logic [31:0] img [8];
  always #5 clk = ~clk;
  imem_boot_if #(.ADDR_W(8)) b0 ();
  imem_boot_if #(.ADDR_W(2)) b1 ();
  assign b0.prog_valid = pv;
  assign b0.prog_data = pd;
  assign b0.prog_last = pl;
  assign b1.prog_valid = pv;
  assign b1.prog_data = pd;
  assign b1.prog_last = pl;
  imem_boot_ctrl #(.DEPTH(256), .RELEASE_DELAY(RD)) u0 (
    .clk(clk), .reset(reset), .bus(b0), .reload(reload),
    .core_reset(cr0), .boot_done(bd0), .boot_err(be0), .word_count(wc0)
  );
  imem_boot_ctrl #(.DEPTH(4), .RELEASE_DELAY(RD)) u1 (
    .clk(clk), .reset(reset), .bus(b1), .reload(reload),
    .core_reset(cr1), .boot_done(bd1), .boot_err(be1), .word_count(wc1)
  );
  function automatic int dep(input int i);
    return i == 0 ? 256 : 4;
  endfunction
  function automatic bit exp_we(input int i);
    return mode[i] == M_LOAD && !reset && pv && cnt[i] < dep(i) && !(CHK && pl);
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, e, cyc);
    end
  endtask
  // Model: phase per instance; HOLD ends at a precomputed release cycle.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit w;
      w = exp_we(i);
      if (reset) begin
        mode[i] = M_LOAD;
        cnt[i] = 0;
        sum[i] = '0;
      end else if (mode[i] == M_LOAD && pv) begin
        if (w) begin
          mm[i][cnt[i]] = pd;
          mv[i][cnt[i]] = 1'b1;
          cnt[i]++;
          sum[i] += pd;
        end
        if (CHK && pl) mode[i] = (sum[i] == pd) ? M_HOLD : M_ERR;
        else if (!w) mode[i] = M_ERR;
        else if (pl) mode[i] = M_HOLD;
        if (mode[i] == M_HOLD) rel[i] = cyc + RD + 1;
      end else if (mode[i] == M_HOLD) begin
        if (cyc + 1 >= rel[i]) mode[i] = M_RUN;
      end else if ((mode[i] == M_RUN || mode[i] == M_ERR) && reload) begin
        mode[i] = M_LOAD;
        cnt[i] = 0;
        sum[i] = '0;
      end
    end
    cyc++;
  end
  always @(negedge clk) if (armed) begin
    for (int i = 0; i < 2; i++) begin
      logic rdy, we, cr, bd, be;
      logic [31:0] wa, wd, wc;
      rdy = i == 0 ? b0.prog_ready : b1.prog_ready;
      we = i == 0 ? b0.imem_we : b1.imem_we;
      wa = i == 0 ? 32'(b0.imem_waddr) : 32'(b1.imem_waddr);
      wd = i == 0 ? b0.imem_wdata : b1.imem_wdata;
      cr = i == 0 ? cr0 : cr1;
      bd = i == 0 ? bd0 : bd1;
      be = i == 0 ? be0 : be1;
      wc = i == 0 ? 32'(wc0) : 32'(wc1);
      chk($sformatf("prog_ready[%0d]", i), rdy, mode[i] == M_LOAD && !reset);
      chk($sformatf("imem_we[%0d]", i), we, exp_we(i));
      chk($sformatf("core_reset[%0d]", i), cr, mode[i] != M_RUN);
      chk($sformatf("boot_done[%0d]", i), bd, mode[i] == M_RUN);
      chk($sformatf("boot_err[%0d]", i), be, mode[i] == M_ERR);
      chk($sformatf("word_count[%0d]", i), wc, cnt[i]);
      if (exp_we(i)) begin
        chk($sformatf("imem_waddr[%0d]", i), wa, cnt[i] % dep(i));
        chk($sformatf("imem_wdata[%0d]", i), wd, pd);
      end
      if (we === 1'b1) sh[i][wa] = wd;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input logic [31:0] d, input logic l);
    pv = 1'b1;
    pd = d;
    pl = l;
    tick();
    pv = 1'b0;
    pl = 1'b0;
  endtask
  task automatic image(input int n, input bit gap, input bit good);
    logic [31:0] s = '0;
    for (int k = 0; k < n; k++) begin
      beat(img[k], !CHK && k == n - 1);
      s += img[k];
      if (gap) tick();
    end
    if (CHK) beat(good ? s : ~s, 1'b1);
  endtask
  task automatic wait_run();
    int n = 0;
    while (bd0 !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("run_reached", bd0, 1'b1);
    tick();
  endtask
  task automatic do_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask
  initial begin
    int n;
    repeat (2) tick();
    reset = 1'b0;
    armed = 1'b1;
    @(negedge clk);
    chk("rst_core_reset", cr0, 1'b1);
    chk("rst_word_count", wc0, 9'd0);
    chk("rst_boot_done", bd0, 1'b0);
    tick();
    beat(32'h3e800093, 1'b0);
    beat(32'h00108133, !CHK);
    if (CHK) beat(32'h3e9081c6, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cr0 === 1'b1 && n < 10);
    chk("release_latency", n, 3);
    chk("basic_boot_done", bd0, 1'b1);
    chk("basic_word_count", wc0, 9'd2);
    chk("basic_addr0", sh[0][0], 32'h3e800093);
    chk("basic_addr1", sh[0][1], 32'h00108133);
    tick();
    do_reload();
    @(negedge clk);
    chk("reload_core_reset", cr0, 1'b1);
    chk("reload_word_count", wc0, 9'd0);
    tick();
    img[0] = 32'h00000013; img[1] = 32'h00100093; img[2] = 32'h00200113; img[3] = 32'h002081b3;
    image(4, 1'b1, 1'b1);
    wait_run();
    chk("bp_word_count", wc0, 9'd4);
    chk("bp_addr3", sh[0][3], 32'h002081b3);
    chk("bp_small_word_count", wc1, 3'd4);
    do_reload();
    for (int k = 0; k < 5; k++) beat(32'h11110000 + k, 1'b0);
    @(negedge clk);
    chk("ovf_boot_err", be1, 1'b1);
    chk("ovf_core_reset", cr1, 1'b1);
    chk("ovf_word_count", wc1, 3'd4);
    chk("ovf_addr3", sh[1][3], 32'h11110003);
    chk("ovf_big_count", wc0, 9'd5);
    tick();
    do_reload();
    @(negedge clk);
    chk("ovf_reload_count", wc1, 3'd0);
    chk("ovf_reload_err", be1, 1'b0);
    chk("ovf_reload_ready", b1.prog_ready, 1'b1);
    chk("reload_ignored_load", wc0, 9'd5);
    tick();
    beat(CHK ? 32'h5555000a : 32'h00000073, 1'b1);
    wait_run();
    do_reload();
    img[0] = 32'h00500293;
    image(1, 1'b0, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("hold_rst_core_reset", cr0, 1'b1);
    chk("hold_rst_boot_done", bd0, 1'b0);
    chk("hold_rst_ready", b0.prog_ready, 1'b1);
    tick();
    img[0] = 32'h00000013;
    image(1, 1'b0, 1'b1);
    wait_run();
    do_reload();
    @(negedge clk);
    chk("run_reload_core_reset", cr0, 1'b1);
    tick();
    img[0] = 32'hdeadbeef;
    image(1, 1'b0, 1'b1);
    wait_run();
    chk("reimage_addr0", sh[0][0], 32'hdeadbeef);
    chk("reimage_count", wc0, 9'd1);
`ifdef IMEM_BOOT_CHECKSUM_EN
    do_reload();
    beat(32'h3e800093, 1'b0);
    beat(32'h00108133, 1'b0);
    beat(32'h00000000, 1'b1);
    @(negedge clk);
    chk("cksum_bad_err", be0, 1'b1);
    chk("cksum_bad_core_reset", cr0, 1'b1);
    tick();
`endif
    repeat (2) tick();
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 8; a++)
        if (a < dep(i) && mv[i][a]) chk($sformatf("mem[%0d][%0d]", i, a), sh[i][a], mm[i][a]);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/imem_boot_ctrl.md
# imem_boot_ctrl

Boot-time loader and reset sequencer for the pipelined RISC-V core. Accepts a stream of instruction words on a valid/ready port, writes them into the fetch stage's instruction memory from address 0 upward, and holds the core in reset until the load completes plus a programmable settle delay. Sits between `top`'s external reset/program interface and the core, so the instruction-memory image is loaded through hardware rather than by backdoor writes from a testbench.

## Interface
Parameters:
- `DEPTH`, 256: instruction memory size in 32-bit words; power of two, at least 2.
- `ADDR_W`, `$clog2(DEPTH)`: word-address width.
- `RELEASE_DELAY`, 2: cycles `core_reset` stays high after the final beat; at least 1.

Ports:
- `clk`, in, 1: single clock; all state changes on its rising edge.
- `reset`, in, 1: synchronous, active-high.
- `prog_valid`, in, 1: program beat available.
- `prog_ready`, out, 1: controller accepts a beat this cycle.
- `prog_data`, in, 32: instruction word, or checksum on the final beat when checksum is compiled in.
- `prog_last`, in, 1: marks the final beat of the image.
- `reload`, in, 1: restarts loading from RUN or ERR.
- `imem_we`, out, 1: instruction-memory write enable.
- `imem_waddr`, out, ADDR_W: word address.
- `imem_wdata`, out, 32: write data.
- `core_reset`, out, 1: synchronous reset to the pipeline.
- `boot_done`, out, 1: image loaded, core running.
- `boot_err`, out, 1: load failed.
- `word_count`, out, ADDR_W+1: instruction words written in the current or most recent load.

## Operation
- States: LOAD, HOLD, RUN, ERR.
- Reset state: LOAD. Count 0, hold counter 0, `core_reset`=1, `boot_done`=0, `boot_err`=0, `word_count`=0.
- While `reset` is high: `prog_ready`=0 and `imem_we`=0.
- `prog_ready` = (state==LOAD) && !`reset`. A beat transfers when `prog_valid && prog_ready`.
- LOAD, write path:
  - `imem_we`, `imem_waddr`=count[ADDR_W-1:0] and `imem_wdata`=`prog_data` are combinational in the transfer cycle.
  - Each write increments the count; `word_count` mirrors the count.
- LOAD, overflow: any beat that would be written when count==DEPTH is not written; the next state is ERR.
- LOAD, final beat: a transfer with `prog_last` (and no error) loads the hold counter with RELEASE_DELAY; the next state is HOLD.
- HOLD:
  - Hold counter decrements each cycle; the state becomes RUN on the edge where the counter reaches 0.
  - `prog_valid` is ignored and `reload` is ignored.
- RUN: `core_reset`=0 and `boot_done`=1, both registered. `reload` moves the state to LOAD.
- ERR: `core_reset`=1, `boot_err`=1. `reload` moves the state to LOAD.
- Reload from RUN or ERR: on the next edge, count=0, `core_reset`=1, `boot_done`=0, `boot_err`=0. Instruction memory contents are not cleared.
- `reload` is ignored in LOAD and HOLD.
- `prog_last` with no preceding beats is legal: a 1-word image (or, with checksum compiled in, a 0-word image).

## Timing
- Write latency: 0 cycles; memory write occurs on the same edge as the handshake.
- Final handshake on the edge ending cycle T:
  - HOLD during cycles T+1 … T+RELEASE_DELAY.
  - RUN from T+RELEASE_DELAY+1; `core_reset` falls and `boot_done` rises in that cycle.
- Throughput: one beat per cycle in LOAD; `prog_ready` stays high back-to-back.
- `reset` asserted mid-load or mid-HOLD: next cycle is the full reset state. Any partially written image remains in memory, and `core_reset` is 1.
- `reset` and `reload` both high: `reset` wins.

## Configuration
- Macro: `IMEM_BOOT_CHECKSUM_EN`.
- Defined:
  - A 32-bit wrapping sum of all written words is accumulated and cleared on reset or reload.
  - The `prog_last` beat carries the expected sum and is never written to memory.
  - A last beat at count==DEPTH is legal.
  - Match → HOLD; mismatch → ERR.
- Undefined: the `prog_last` beat is an ordinary instruction (written, counted); no summing logic.

## Test plan
- Basic load, DEPTH=256, RELEASE_DELAY=2, checksum off:
  - Stimulus: beats 0x3e800093, then 0x00108133 with last.
  - Required: writes addr0=0x3e800093 and addr1=0x00108133; `word_count`=2; `core_reset` low exactly 3 cycles after the last handshake; `boot_done`=1.
- Backpressure: `prog_valid` toggling 1,0,1,0 over 4 words → exactly 4 writes at addresses 0–3; no write in idle cycles.
- Overflow, DEPTH=4:
  - Stimulus: 5 beats, none with last.
  - Required: 4 writes; 5th beat not written; `boot_err`=1; `core_reset` stays 1.
  - Follow-up: `reload` pulse → LOAD, `word_count`=0, `boot_err`=0.
- Reset mid-HOLD: `reset` on the cycle after the last handshake → `core_reset`=1, `boot_done`=0, `prog_ready`=1 one cycle after `reset` falls.
- Reload from RUN: `reload` in RUN → `core_reset`=1 next cycle; a new 1-word image is written to addr0.
- Checksum, `IMEM_BOOT_CHECKSUM_EN` defined:
  - Stimulus: words 0x3e800093, 0x00108133, then last beat 0x3e9081c6 → RUN with `word_count`=2.
  - Repeat with last beat 0x00000000 → ERR.
